seg7_frame_reader: RTL and testbench

- Reverse direction of the switch-to-7-segment display path. Accepts a serial stream of six active-low 7-segment patterns (HEX5 first, HEX0 last) over a valid/ready handshake.
- Decodes each pattern back to a 4-bit character code and assembles a six-character frame.
- Classifies the frame as "banana", "bad" or numeric, then presents it on a held valid/ready output.
- Used by the bench and the board-scan path to read displayed results back into binary.

---
 rtl/seg7_frame_reader.sv | 180 ++++++++++++++++++
 tb/tb_seg7_frame_reader.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/seg7_frame_reader.sv
// Reads six active-low 7-segment patterns (HEX5 first) back into 4-bit character
// codes, assembles the frame, classifies it and holds it until the consumer takes it.
module seg7_frame_reader #(
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [6:0]  seg_in,
    input  logic        seg_sof,
    input  logic        seg_valid,
    output logic        seg_ready,
    output logic        frame_valid,
    input  logic        frame_ready,
    output logic [23:0] chars,
    output logic        is_banana,
    output logic        is_bad,
    output logic        num_ok,
    output logic [6:0]  num,
    output logic        err,
    output logic        resync,
    output logic        drop
);

    typedef enum logic {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } state_t;

    localparam logic [3:0] CODE_A       = 4'd10;
    localparam logic [3:0] CODE_B       = 4'd11;
    localparam logic [3:0] CODE_D       = 4'd12;
    localparam logic [3:0] CODE_N       = 4'd13;
    localparam logic [3:0] CODE_BLANK   = 4'd14;
    localparam logic [3:0] CODE_ILLEGAL = 4'd15;

    state_t      state_q, state_d;
    logic [2:0]  idx_q, idx_d;
    logic [19:0] buf_q, buf_d;      // HEX5..HEX1 of the frame being collected
    logic [23:0] chars_q, chars_d;
    logic        is_banana_q, is_banana_d;
    logic        is_bad_q, is_bad_d;
    logic        num_ok_q, num_ok_d;
    logic [6:0]  num_q, num_d;
    logic        err_q, err_d;
    logic        resync_q, resync_d;
    logic        drop_q, drop_d;

    logic [6:0]  seg_norm;
    logic [3:0]  seg_code;
    logic [23:0] frame_full;
    logic [5:0]  nib_illegal;
    logic        accept;

    // Exact-match decode; patterns are in active-low form, bit6=g .. bit0=a.
    function automatic logic [3:0] decode_seg(input logic [6:0] p);
        logic [3:0] code;
        case (p)
            7'b1000000: code = 4'd0;
            7'b1111001: code = 4'd1;
            7'b0100100: code = 4'd2;
            7'b0110000: code = 4'd3;
            7'b0011001: code = 4'd4;
            7'b0010010: code = 4'd5;
            7'b0000010: code = 4'd6;
            7'b1111000: code = 4'd7;
            7'b0000000: code = 4'd8;
            7'b0010000: code = 4'd9;
            7'b0001000: code = CODE_A;
            7'b0000011: code = CODE_B;
            7'b0100001: code = CODE_D;
            7'b0101011: code = CODE_N;
            7'b1111111: code = CODE_BLANK;
            default:    code = CODE_ILLEGAL;
        endcase
        return code;
    endfunction

    assign seg_norm   = SEG_ACTIVE_LOW ? seg_in : ~seg_in;
    assign seg_code   = decode_seg(seg_norm);
    assign frame_full = {buf_q, seg_code};
    assign accept     = seg_valid & seg_ready;

    generate
        for (genvar gi = 0; gi < 6; gi++) begin : g_nib
            assign nib_illegal[gi] = (frame_full[gi*4 +: 4] == CODE_ILLEGAL);
        end
    endgenerate

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        buf_d       = buf_q;
        chars_d     = chars_q;
        is_banana_d = is_banana_q;
        is_bad_d    = is_bad_q;
        num_ok_d    = num_ok_q;
        num_d       = num_q;
        err_d       = err_q;
        resync_d    = 1'b0;
        drop_d      = 1'b0;

        case (state_q)
            COLLECT: begin
                if (accept) begin
                    if (seg_sof) begin
                        // A start-of-frame always restarts; any partial frame is dropped.
                        buf_d    = {seg_code, 16'h0000};
                        idx_d    = 3'd1;
                        resync_d = (idx_q != 3'd0);
                    end else if (idx_q == 3'd0) begin
                        drop_d = 1'b1;
                    end else if (idx_q == 3'd5) begin
                        state_d     = HOLD;
                        idx_d       = 3'd0;
                        chars_d     = frame_full;
                        is_banana_d = (frame_full == {CODE_B, CODE_A, CODE_N, CODE_A, CODE_N, CODE_A});
                        is_bad_d    = (frame_full[23:8] == {CODE_B, CODE_A, CODE_D, CODE_BLANK});
                        num_ok_d    = (frame_full[7:4] <= 4'd9) && (frame_full[3:0] <= 4'd9);
                        num_d       = num_ok_d ? (7'(frame_full[7:4]) * 7'd10 + 7'(frame_full[3:0]))
                                               : 7'd0;
                        err_d       = |nib_illegal;
                    end else begin
                        buf_d[4*(3'd4 - idx_q) +: 4] = seg_code;
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            HOLD: begin
                if (frame_ready) begin
                    state_d = COLLECT;
                    idx_d   = 3'd0;
                end
            end
            default: begin
                state_d = COLLECT;
                idx_d   = 3'd0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= COLLECT;
            idx_q       <= 3'd0;
            buf_q       <= '0;
            chars_q     <= '0;
            is_banana_q <= 1'b0;
            is_bad_q    <= 1'b0;
            num_ok_q    <= 1'b0;
            num_q       <= '0;
            err_q       <= 1'b0;
            resync_q    <= 1'b0;
            drop_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            buf_q       <= buf_d;
            chars_q     <= chars_d;
            is_banana_q <= is_banana_d;
            is_bad_q    <= is_bad_d;
            num_ok_q    <= num_ok_d;
            num_q       <= num_d;
            err_q       <= err_d;
            resync_q    <= resync_d;
            drop_q      <= drop_d;
        end
    end

    assign seg_ready   = (state_q == COLLECT);
    assign frame_valid = (state_q == HOLD);
    assign chars       = chars_q;
    assign is_banana   = is_banana_q;
    assign is_bad      = is_bad_q;
    assign num_ok      = num_ok_q;
    assign num         = num_q;
    assign err         = err_q;
    assign resync      = resync_q;
    assign drop        = drop_q;

endmodule

// File: tb/tb_seg7_frame_reader.sv
// Directed and randomized frames for seg7_frame_reader, checked against a
// character-level model of the decode and classification rules.
module tb_seg7_frame_reader;

    logic        clk = 1'b0;
    logic        reset;
    logic [6:0]  seg_in;
    logic        seg_sof;
    logic        seg_valid;
    logic        seg_ready;
    logic        frame_valid;
    logic        frame_ready;
    logic [23:0] chars;
    logic        is_banana, is_bad, num_ok, err, resync, drop;
    logic [6:0]  num;

    int vectors = 0;
    int miscompares = 0;

    logic [6:0] pat [0:14];   // code -> active-low pattern
    int fc [0:5];             // codes of the frame being sent, fc[0] = HEX5

    seg7_frame_reader #(.SEG_ACTIVE_LOW(1'b1)) dut (
        .clk(clk), .reset(reset),
        .seg_in(seg_in), .seg_sof(seg_sof), .seg_valid(seg_valid), .seg_ready(seg_ready),
        .frame_valid(frame_valid), .frame_ready(frame_ready),
        .chars(chars), .is_banana(is_banana), .is_bad(is_bad),
        .num_ok(num_ok), .num(num), .err(err), .resync(resync), .drop(drop)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int decode_model(input logic [6:0] p);
        for (int i = 0; i < 15; i++)
            if (pat[i] == p) return i;
        return 15;
    endfunction

    function automatic logic [6:0] pattern_for(input int code);
        logic [6:0] p;
        if (code < 15) return pat[code];
        do p = 7'($urandom); while (decode_model(p) != 15);
        return p;
    endfunction

    task automatic send_beat(input logic [6:0] p, input bit sof, input bit exp_resync, input bit exp_drop);
        @(negedge clk);
        seg_in = p; seg_sof = sof; seg_valid = 1'b1;
        check("seg_ready_collect", seg_ready, 1'b1);
        @(posedge clk); #1;
        seg_valid = 1'b0; seg_sof = 1'b0;
        check("resync", resync, exp_resync);
        check("drop", drop, exp_drop);
        $display("beat p=%b sof=%0d resync=%0d drop=%0d", p, sof, resync, drop);
    endtask

    // Sends fc[0..5]; the first beat optionally lands mid-frame (resync expected).
    task automatic send_frame(input bit first_resync, input logic [6:0] hex3_override, input bit use_override);
        for (int i = 0; i < 6; i++) begin
            logic [6:0] p;
            p = (use_override && i == 2) ? hex3_override : pattern_for(fc[i]);
            send_beat(p, i == 0, (i == 0) && first_resync, 1'b0);
            if (i < 5) check("frame_valid_collect", frame_valid, 1'b0);
        end
    endtask

    task automatic check_frame(input int hold_cycles);
        logic [23:0] ech;
        bit eban, ebad, enok, eerr;
        int en;
        ech = '0; eerr = 0;
        for (int i = 0; i < 6; i++) begin
            ech = (ech << 4) | 24'(fc[i]);
            if (fc[i] == 15) eerr = 1;
        end
        // b=11 a=10 d=12 n=13 blank=14
        eban = (fc[0] == 11) && (fc[1] == 10) && (fc[2] == 13) && (fc[3] == 10) && (fc[4] == 13) && (fc[5] == 10);
        ebad = (fc[0] == 11) && (fc[1] == 10) && (fc[2] == 12) && (fc[3] == 14);
        enok = (fc[4] <= 9) && (fc[5] <= 9);
        en   = enok ? fc[4] * 10 + fc[5] : 0;
        check("frame_valid_rise", frame_valid, 1'b1);
        check("chars", chars, ech);
        check("is_banana", is_banana, eban);
        check("is_bad", is_bad, ebad);
        check("num_ok", num_ok, enok);
        check("num", num, en);
        check("err", err, eerr);
        $display("frame chars=%h banana=%0d bad=%0d num_ok=%0d num=%0d err=%0d",
                 chars, is_banana, is_bad, num_ok, num, err);
        for (int c = 0; c < hold_cycles; c++) begin
            @(negedge clk);
            seg_in = pat[$urandom_range(0, 14)]; seg_sof = 1'b1; seg_valid = 1'b1;
            check("seg_ready_hold", seg_ready, 1'b0);
            @(posedge clk); #1;
            check("frame_valid_hold", frame_valid, 1'b1);
            check("chars_hold", chars, ech);
            check("num_hold", num, en);
        end
        @(negedge clk);
        seg_in = pat[3]; seg_sof = 1'b1; seg_valid = 1'b1;   // must not be taken in the handshake cycle
        frame_ready = 1'b1;
        @(posedge clk); #1;
        frame_ready = 1'b0; seg_valid = 1'b0; seg_sof = 1'b0;
        check("frame_valid_fall", frame_valid, 1'b0);
        check("seg_ready_after", seg_ready, 1'b1);
    endtask

    task automatic set_frame(input int c0, input int c1, input int c2, input int c3, input int c4, input int c5);
        fc[0] = c0; fc[1] = c1; fc[2] = c2; fc[3] = c3; fc[4] = c4; fc[5] = c5;
    endtask

    initial begin
        pat[0]  = 7'b1000000; pat[1]  = 7'b1111001; pat[2]  = 7'b0100100; pat[3]  = 7'b0110000;
        pat[4]  = 7'b0011001; pat[5]  = 7'b0010010; pat[6]  = 7'b0000010; pat[7]  = 7'b1111000;
        pat[8]  = 7'b0000000; pat[9]  = 7'b0010000; pat[10] = 7'b0001000; pat[11] = 7'b0000011;
        pat[12] = 7'b0100001; pat[13] = 7'b0101011; pat[14] = 7'b1111111;

        reset = 1'b1; seg_in = '0; seg_sof = 1'b0; seg_valid = 1'b0; frame_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_frame_valid", frame_valid, 1'b0);
        check("rst_chars", chars, 24'h0);
        check("rst_flags", {is_banana, is_bad, num_ok, err, resync, drop}, 6'b0);
        check("rst_num", num, 7'd0);
        @(negedge clk); reset = 1'b0;
        check("rst_seg_ready", seg_ready, 1'b1);

        // banana
        set_frame(11, 10, 13, 10, 13, 10);
        send_frame(1'b0, 7'h0, 1'b0);
        check_frame(0);

        // bad + "19", consumer stalls five cycles
        set_frame(11, 10, 12, 14, 1, 9);
        send_frame(1'b0, 7'h0, 1'b0);
        check_frame(5);

        // four blanks then "07"
        set_frame(14, 14, 14, 14, 0, 7);
        send_frame(1'b0, 7'h0, 1'b0);
        check_frame(1);

        // three beats, then a fresh sof restarts the frame
        send_beat(pat[5], 1'b1, 1'b0, 1'b0);
        send_beat(pat[6], 1'b0, 1'b0, 1'b0);
        send_beat(pat[7], 1'b0, 1'b0, 1'b0);
        set_frame(2, 4, 6, 8, 4, 2);
        send_frame(1'b1, 7'h0, 1'b0);
        check_frame(0);

        // stray beats after reset are dropped
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        send_beat(pat[1], 1'b0, 1'b0, 1'b1);
        send_beat(pat[2], 1'b0, 1'b0, 1'b1);
        check("frame_valid_drop", frame_valid, 1'b0);

        // illegal HEX3 pattern
        set_frame(3, 3, 15, 3, 3, 3);
        send_frame(1'b0, 7'b1010101, 1'b1);
        check_frame(0);

        // reset after four beats loses the partial frame
        send_beat(pat[9], 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) send_beat(pat[8], 1'b0, 1'b0, 1'b0);
        @(negedge clk); reset = 1'b1; #1;
        check("midrst_chars", chars, 24'h0);
        check("midrst_err", err, 1'b0);
        @(negedge clk); reset = 1'b0;
        check("midrst_frame_valid", frame_valid, 1'b0);
        set_frame(9, 8, 7, 6, 5, 4);
        send_frame(1'b0, 7'h0, 1'b0);
        check_frame(0);

        // randomized frames with occasional stray beats and restarts
        for (int it = 0; it < 40; it++) begin
            int sel;
            bit do_restart;
            if ($urandom_range(0, 3) == 0)
                for (int s = 0; s < $urandom_range(1, 2); s++)
                    send_beat(pattern_for($urandom_range(0, 15)), 1'b0, 1'b0, 1'b1);
            do_restart = ($urandom_range(0, 3) == 0);
            if (do_restart) begin
                int k;
                k = $urandom_range(1, 5);
                for (int s = 0; s < k; s++)
                    send_beat(pattern_for($urandom_range(0, 15)), s == 0, 1'b0, 1'b0);
            end
            sel = $urandom_range(0, 7);
            if (sel == 0)      set_frame(11, 10, 13, 10, 13, 10);
            else if (sel == 1) set_frame(11, 10, 12, 14, $urandom_range(0, 15), $urandom_range(0, 15));
            else
                for (int i = 0; i < 6; i++) fc[i] = (i >= 4) ? $urandom_range(0, 12) : $urandom_range(0, 15);
            send_frame(do_restart, 7'h0, 1'b0);
            check_frame($urandom_range(0, 3));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
